// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer.
// Provides the default sizing constants and the entry record type used by
// the ROB top level and its operand-lookup view.
package rob_pkg;

    localparam int TAG_W  = 5;
    localparam int DEPTH  = 32;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;

    // One reorder-buffer entry as seen by commit and operand lookup.
    typedef struct packed {
        logic              busy;
        logic              ready;
        logic              wen;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_if.sv
// Bundle of all ROB-facing signals: flush, dispatch, CDB, operand lookup,
// RST commit-side notification and register-file write port.
//   slave  : the ROB side (consumes requests, produces tags/results)
//   master : the core/bench side
interface rob_if
    import rob_pkg::*;
#(
    parameter int TAG_W  = rob_pkg::TAG_W,
    parameter int DATA_W = rob_pkg::DATA_W
);
    logic              flush_rob;

    logic              disp_valid_rob;
    logic [RD_W-1:0]   disp_rd_rob;
    logic              disp_wen_rob;
    logic              disp_ready_rob;
    logic [TAG_W-1:0]  disp_tag_rob;

    logic              cdb_valid_rob;
    logic [TAG_W-1:0]  cdb_tag_rob;
    logic [DATA_W-1:0] cdb_data_rob;

    logic [TAG_W-1:0]  rs_tag_rob;
    logic [DATA_W-1:0] rs_data_rob;
    logic              rs_ready_rob;
    logic [TAG_W-1:0]  rt_tag_rob;
    logic [DATA_W-1:0] rt_data_rob;
    logic              rt_ready_rob;

    logic [TAG_W-1:0]  RB_tag_rst;
    logic              RB_valid_rst;
    logic [RD_W-1:0]   commit_addr_rob;
    logic [DATA_W-1:0] commit_data_rob;
    logic              commit_wen_rob;

    modport slave (
        input  flush_rob,
        input  disp_valid_rob, disp_rd_rob, disp_wen_rob,
        output disp_ready_rob, disp_tag_rob,
        input  cdb_valid_rob, cdb_tag_rob, cdb_data_rob,
        input  rs_tag_rob, rt_tag_rob,
        output rs_data_rob, rs_ready_rob, rt_data_rob, rt_ready_rob,
        output RB_tag_rst, RB_valid_rst,
        output commit_addr_rob, commit_data_rob, commit_wen_rob
    );

    modport master (
        output flush_rob,
        output disp_valid_rob, disp_rd_rob, disp_wen_rob,
        input  disp_ready_rob, disp_tag_rob,
        output cdb_valid_rob, cdb_tag_rob, cdb_data_rob,
        output rs_tag_rob, rt_tag_rob,
        input  rs_data_rob, rs_ready_rob, rt_data_rob, rt_ready_rob,
        input  RB_tag_rst, RB_valid_rst,
        input  commit_addr_rob, commit_data_rob, commit_wen_rob
    );

endinterface

// File: rtl/rob_ptr.sv
// Wrapping W-bit circular pointer used for the ROB head and tail.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset (pointer -> 0)
//   clr   - synchronous clear to 0, wins over inc
//   inc   - advance by one, wrapping modulo 2**W
//   ptr   - current pointer value
module rob_ptr #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            // Natural overflow of the W-bit add provides the wrap to 0.
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/rob.sv
// Reorder buffer for the Tomasulo MIPS core.
// Allocates a tag per dispatched instruction, captures CDB results, serves
// operand values (with same-cycle CDB bypass) and retires one entry per
// cycle in program order, driving the register-file write and RST tag clear.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - rob_if.slave: flush, dispatch, CDB, rs/rt lookup, commit outputs
module rob
    import rob_pkg::*;
#(
    parameter int DEPTH  = rob_pkg::DEPTH,
    parameter int TAG_W  = rob_pkg::TAG_W,
    parameter int DATA_W = rob_pkg::DATA_W
) (
    input  logic clock,
    input  logic reset,
    rob_if.slave bus
);

    localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(DEPTH);

    // Control state (reset)
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  ready_q, ready_d;
    logic [TAG_W:0]    count_q, count_d;

    // Payload (no reset; qualified by busy/ready)
    logic [DEPTH-1:0]  wen_q, wen_d;
    logic [RD_W-1:0]   rd_q   [DEPTH];
    logic [RD_W-1:0]   rd_d   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    // Registered commit outputs
    logic [TAG_W-1:0]  rb_tag_q, rb_tag_d;
    logic              rb_valid_q, rb_valid_d;
    logic [RD_W-1:0]   commit_addr_q, commit_addr_d;
    logic [DATA_W-1:0] commit_data_q, commit_data_d;
    logic              commit_wen_q, commit_wen_d;

    logic [TAG_W-1:0]  head, tail;
    logic              full;
    logic              disp_fire;
    logic              commit_fire;
    logic              cdb_hit;
    rob_entry_t        head_ent;

    rob_ptr #(.W(TAG_W)) u_head (
        .clock (clock),
        .reset (reset),
        .clr   (bus.flush_rob),
        .inc   (commit_fire),
        .ptr   (head)
    );

    rob_ptr #(.W(TAG_W)) u_tail (
        .clock (clock),
        .reset (reset),
        .clr   (bus.flush_rob),
        .inc   (disp_fire),
        .ptr   (tail)
    );

    // Full/empty come from count alone; head==tail is ambiguous.
    always_comb begin
        full        = (count_q == CNT_FULL);
        head_ent    = '{busy:  busy_q[head],
                        ready: ready_q[head],
                        wen:   wen_q[head],
                        rd:    rd_q[head],
                        data:  data_q[head]};
        disp_fire   = bus.disp_valid_rob && !full && !bus.flush_rob;
        commit_fire = head_ent.busy && head_ent.ready && !bus.flush_rob;
        cdb_hit     = bus.cdb_valid_rob && busy_q[bus.cdb_tag_rob] &&
                      !ready_q[bus.cdb_tag_rob] && !bus.flush_rob;
    end

    always_comb begin
        busy_d        = busy_q;
        ready_d       = ready_q;
        count_d       = count_q;
        wen_d         = wen_q;
        rd_d          = rd_q;
        data_d        = data_q;
        rb_tag_d      = rb_tag_q;
        rb_valid_d    = 1'b0;
        commit_addr_d = commit_addr_q;
        commit_data_d = commit_data_q;
        commit_wen_d  = 1'b0;

        if (bus.flush_rob) begin
            busy_d        = '0;
            ready_d       = '0;
            count_d       = '0;
            rb_tag_d      = '0;
            commit_addr_d = '0;
            commit_data_d = '0;
        end else begin
            if (commit_fire) begin
                busy_d[head]  = 1'b0;
                ready_d[head] = 1'b0;
                rb_tag_d      = head;
                rb_valid_d    = head_ent.wen;
                commit_wen_d  = head_ent.wen;
                commit_addr_d = head_ent.rd;
                commit_data_d = head_ent.data;
            end
            // A CDB hit can never target the committing head (already ready)
            // nor the dispatching tail (not busy unless full).
            if (cdb_hit) begin
                ready_d[bus.cdb_tag_rob] = 1'b1;
                data_d[bus.cdb_tag_rob]  = bus.cdb_data_rob;
            end
            if (disp_fire) begin
                busy_d[tail]  = 1'b1;
                ready_d[tail] = 1'b0;
                wen_d[tail]   = bus.disp_wen_rob;
                rd_d[tail]    = bus.disp_rd_rob;
            end
            count_d = count_q + (TAG_W+1)'(disp_fire) - (TAG_W+1)'(commit_fire);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q        <= '0;
            ready_q       <= '0;
            count_q       <= '0;
            rb_tag_q      <= '0;
            rb_valid_q    <= 1'b0;
            commit_addr_q <= '0;
            commit_data_q <= '0;
            commit_wen_q  <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            ready_q       <= ready_d;
            count_q       <= count_d;
            rb_tag_q      <= rb_tag_d;
            rb_valid_q    <= rb_valid_d;
            commit_addr_q <= commit_addr_d;
            commit_data_q <= commit_data_d;
            commit_wen_q  <= commit_wen_d;
        end
    end

    always_ff @(posedge clock) begin
        wen_q  <= wen_d;
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    // Operand lookup with same-cycle CDB bypass.
    always_comb begin
        bus.rs_data_rob  = data_q[bus.rs_tag_rob];
        bus.rs_ready_rob = ready_q[bus.rs_tag_rob];
        if (bus.cdb_valid_rob && (bus.cdb_tag_rob == bus.rs_tag_rob)) begin
            bus.rs_data_rob  = bus.cdb_data_rob;
            bus.rs_ready_rob = 1'b1;
        end
        bus.rt_data_rob  = data_q[bus.rt_tag_rob];
        bus.rt_ready_rob = ready_q[bus.rt_tag_rob];
        if (bus.cdb_valid_rob && (bus.cdb_tag_rob == bus.rt_tag_rob)) begin
            bus.rt_data_rob  = bus.cdb_data_rob;
            bus.rt_ready_rob = 1'b1;
        end
    end

    assign bus.disp_ready_rob  = !full;
    assign bus.disp_tag_rob    = tail;
    assign bus.RB_tag_rst      = rb_tag_q;
    assign bus.RB_valid_rst    = rb_valid_q;
    assign bus.commit_addr_rob = commit_addr_q;
    assign bus.commit_data_rob = commit_data_q;
    assign bus.commit_wen_rob  = commit_wen_q;

endmodule
